mem_reg_sb: RTL and testbench
=============================

// Module: mem_reg_sb
// PURPOSE
//  Parametrised register file for the pipelined RiSC-16 core. Successor to the 8x16 2R/1W file.
//  Adds a hardwired-zero r0, a same-cycle write-to-read bypass and a per-register scoreboard.
//  Each scoreboard entry counts in-flight writes so decode can stall on RAW hazards.
//  Sits between decode (reads, reservations) and writeback (writes).
// PARAMETERS
//  WORD_LEN      16  data width in bits
//  REG_ADDR_LEN  3   address width; NUM_REGS = 2**REG_ADDR_LEN (local, derived)
//  PEND_W        2   width of each pending-write counter; max outstanding = 2**PEND_W-1
//  BYPASS        1   1: a write this cycle is visible on a read of the same address this cycle
//  ZERO_REG      1   1: r0 reads 0, ignores writes, is never reserved
// PORTS
//  clk      in   1             clock, rising edge
//  rst      in   1             asynchronous, active-low reset
//  src1     in   REG_ADDR_LEN  read address 1
//  src2     in   REG_ADDR_LEN  read address 2
//  out1     out  WORD_LEN      read data 1 (combinational)
//  out2     out  WORD_LEN      read data 2 (combinational)
//  busy1    out  1             src1 has outstanding writes (combinational)
//  busy2    out  1             src2 has outstanding writes (combinational)
//  writeEn  in   1             writeback enable
//  tgt      in   REG_ADDR_LEN  writeback address
//  in       in   WORD_LEN      writeback data
//  rsvEn    in   1             reserve: an instruction targeting rsvTgt issued
//  rsvTgt   in   REG_ADDR_LEN  reservation address
//  rsvFull  out  1             cnt[rsvTgt] at max; a reservation this cycle is dropped
//  err      out  1             sticky: dropped reservation or writeback to cnt==0
// BEHAVIOUR
//  - Reset (rst=0, asynchronous): all regs=0, all cnt=0, err=0; outputs follow immediately.
//  - Write: on posedge with writeEn=1, regs[tgt]<=in. Ignored when tgt==0 and ZERO_REG=1.
//  - Read: outN = regs[srcN], except:
//    * ZERO_REG=1 and srcN==0: outN=0.
//    * BYPASS=1, writeEn=1, tgt==srcN, not (r0 with ZERO_REG=1): outN = in.
//  - Scoreboard, per register on posedge:
//    * rsvEn hit only: cnt+1.
//    * writeEn hit only: cnt-1.
//    * Both hit the same register: cnt unchanged; the reservation supersedes the retiring write.
//  - Saturation: rsvEn with cnt==max and no decrementing writeback in the same cycle.
//    * Reservation dropped, cnt stays at max, err<=1.
//    * rsvFull = (cnt[rsvTgt]==max) regardless of rsvEn.
//  - Underflow: writeEn with cnt[tgt]==0.
//    * Data is still written, cnt stays 0, err<=1.
//  - r0 with ZERO_REG=1: rsvEn/writeEn to r0 never change cnt[0] and never set err. busy for r0 is 0.
//  - busyN = (cnt[srcN] - dec) != 0, where:
//    * dec = 1 if BYPASS=1, writeEn=1 and tgt==srcN; else dec = 0.
//    * A reservation in the same cycle does not raise busy until the next cycle.
//  - err is cleared only by reset.
//  - Reset asserted mid-operation discards all pending counts. There is no partial state.
//  - Latency: writes and counts take effect at posedge; reads are 0-cycle; bypass is 0-cycle.
// TESTING
//  1. Loop i=0..7: writeEn=1, tgt=i, in=i*i+10. Then read src1=i, src2=7-i.
//     -> r1..r7 = 11,14,19,26,35,46,59; r0 reads 0 (ZERO_REG=1).
//  2. writeEn=1, tgt=3, in=16'hBEEF, src1=3 in the same cycle.
//     -> out1=BEEF before the edge (BYPASS=1); BYPASS=0 shows the old value until after the edge.
//  3. rsvEn tgt=5 x2, then src1=5 -> busy1=1, cnt=2.
//     Writeback r5 -> busy1 stays 1. Second writeback -> busy1=0 during that cycle.
//  4. Reserve r4 x3 (PEND_W=2) -> rsvFull=1. Fourth rsvEn -> dropped, err=1.
//     Reserve+writeback r4 in the same cycle -> cnt stays 3.
//  5. writeEn to r6 with cnt=0 -> r6 updated, cnt=0, err=1.
//     rsvEn/writeEn to r0 -> out=0, busy=0, err unchanged.
//  6. Pull rst low between edges while regs/cnt are nonzero.
//     -> out=0, busy=0, rsvFull=0, err=0 immediately, before the next clock edge.

Source files
------------

// File: rtl/mem_reg_sb.sv
// RiSC-16 register file with two combinational read ports, one write port,
// optional hardwired-zero r0, same-cycle write bypass and a per-register pending-write scoreboard.
module mem_reg_sb #(
    parameter int WORD_LEN     = 16,
    parameter int REG_ADDR_LEN = 3,
    parameter int PEND_W       = 2,
    parameter int BYPASS       = 1,
    parameter int ZERO_REG     = 1
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [REG_ADDR_LEN-1:0] src1,
    input  logic [REG_ADDR_LEN-1:0] src2,
    output logic [WORD_LEN-1:0]     out1,
    output logic [WORD_LEN-1:0]     out2,
    output logic                    busy1,
    output logic                    busy2,
    input  logic                    writeEn,
    input  logic [REG_ADDR_LEN-1:0] tgt,
    input  logic [WORD_LEN-1:0]     in,
    input  logic                    rsvEn,
    input  logic [REG_ADDR_LEN-1:0] rsvTgt,
    output logic                    rsvFull,
    output logic                    err
);

    localparam int NUM_REGS = 2 ** REG_ADDR_LEN;
    localparam logic [PEND_W-1:0] CNT_MAX = '1;

    logic [WORD_LEN-1:0] regs    [NUM_REGS];
    logic [PEND_W-1:0]   cnt     [NUM_REGS];
    logic [PEND_W-1:0]   cnt_nxt [NUM_REGS];

    logic                wr_ok;
    logic                rsv_ok;
    logic [NUM_REGS-1:0] wr_vec;
    logic [NUM_REGS-1:0] rsv_vec;
    logic                err_set;
    logic                byp1;
    logic                byp2;

    // r0 is invisible to both the data path and the scoreboard when hardwired
    assign wr_ok  = writeEn && !((ZERO_REG != 0) && (tgt == '0));
    assign rsv_ok = rsvEn   && !((ZERO_REG != 0) && (rsvTgt == '0));

    assign wr_vec  = wr_ok  ? (NUM_REGS'(1) << tgt)    : '0;
    assign rsv_vec = rsv_ok ? (NUM_REGS'(1) << rsvTgt) : '0;

    always_comb begin
        err_set = 1'b0;
        for (int i = 0; i < NUM_REGS; i++) begin
            cnt_nxt[i] = cnt[i];
            if (rsv_vec[i] && !wr_vec[i]) begin
                if (cnt[i] == CNT_MAX) begin
                    err_set = 1'b1;
                end else begin
                    cnt_nxt[i] = cnt[i] + 1'b1;
                end
            end else if (wr_vec[i] && !rsv_vec[i]) begin
                if (cnt[i] == '0) begin
                    err_set = 1'b1;
                end else begin
                    cnt_nxt[i] = cnt[i] - 1'b1;
                end
            end else if (wr_vec[i] && rsv_vec[i] && (cnt[i] == '0)) begin
                // count is unchanged, but the retiring write still had nothing outstanding
                err_set = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                regs[i] <= '0;
                cnt[i]  <= '0;
            end
            err <= 1'b0;
        end else begin
            if (wr_ok) begin
                regs[tgt] <= in;
            end
            for (int i = 0; i < NUM_REGS; i++) begin
                cnt[i] <= cnt_nxt[i];
            end
            if (err_set) begin
                err <= 1'b1;
            end
        end
    end

    assign byp1 = (BYPASS != 0) && wr_ok && (tgt == src1);
    assign byp2 = (BYPASS != 0) && wr_ok && (tgt == src2);

    always_comb begin
        out1 = regs[src1];
        if ((ZERO_REG != 0) && (src1 == '0)) begin
            out1 = '0;
        end else if (byp1) begin
            out1 = in;
        end
    end

    always_comb begin
        out2 = regs[src2];
        if ((ZERO_REG != 0) && (src2 == '0)) begin
            out2 = '0;
        end else if (byp2) begin
            out2 = in;
        end
    end

    // a retiring write this cycle is already credited against the pending count
    assign busy1 = cnt[src1] > PEND_W'(byp1);
    assign busy2 = cnt[src2] > PEND_W'(byp2);

    assign rsvFull = (cnt[rsvTgt] == CNT_MAX);

endmodule

// File: tb/tb_mem_reg_sb.sv
// Scoreboard bench for mem_reg_sb: stimulus queues expected outputs, a negedge monitor compares them.
module tb_mem_reg_sb;

    logic        clk = 1'b0;
    logic        rst;
    logic [2:0]  src1, src2, tgt, rsvTgt;
    logic [15:0] out1, out2, in;
    logic        busy1, busy2, writeEn, rsvEn, rsvFull, err;

    int checks = 0;
    int errors = 0;

    mem_reg_sb dut (
        .clk(clk), .rst(rst),
        .src1(src1), .src2(src2), .out1(out1), .out2(out2),
        .busy1(busy1), .busy2(busy2),
        .writeEn(writeEn), .tgt(tgt), .in(in),
        .rsvEn(rsvEn), .rsvTgt(rsvTgt),
        .rsvFull(rsvFull), .err(err)
    );

    always #5 clk = ~clk;

    // mask bits: [5] out1 [4] out2 [3] busy1 [2] busy2 [1] rsvFull [0] err
    typedef struct {
        string       name;
        logic [5:0]  m;
        logic [15:0] o1;
        logic [15:0] o2;
        logic        b1;
        logic        b2;
        logic        f;
        logic        e;
    } exp_t;

    exp_t exp_q[$];

    task automatic expect_out(input string n, input logic [5:0] m,
                              input logic [15:0] o1, input logic [15:0] o2,
                              input logic b1, input logic b2, input logic f, input logic e);
        exp_t x;
        x.name = n; x.m = m; x.o1 = o1; x.o2 = o2;
        x.b1 = b1; x.b2 = b2; x.f = f; x.e = e;
        exp_q.push_back(x);
    endtask

    task automatic step(input logic we, input logic [2:0] t, input logic [15:0] d,
                        input logic re, input logic [2:0] rt,
                        input logic [2:0] s1, input logic [2:0] s2);
        @(posedge clk);
        #1;
        writeEn = we; tgt = t; in = d;
        rsvEn = re; rsvTgt = rt;
        src1 = s1; src2 = s2;
    endtask

    function automatic logic [15:0] t1_val(input int i);
        return (i == 0) ? 16'd0 : 16'(i * i + 10);
    endfunction

    always @(negedge clk) begin
        while (exp_q.size() > 0) begin
            exp_t x;
            x = exp_q.pop_front();
            if (x.m[5]) begin
                checks++;
                if (out1 !== x.o1) begin
                    errors++;
                    $display("FAIL %s out1 got %h exp %h", x.name, out1, x.o1);
                end
            end
            if (x.m[4]) begin
                checks++;
                if (out2 !== x.o2) begin
                    errors++;
                    $display("FAIL %s out2 got %h exp %h", x.name, out2, x.o2);
                end
            end
            if (x.m[3]) begin
                checks++;
                if (busy1 !== x.b1) begin
                    errors++;
                    $display("FAIL %s busy1 got %b exp %b", x.name, busy1, x.b1);
                end
            end
            if (x.m[2]) begin
                checks++;
                if (busy2 !== x.b2) begin
                    errors++;
                    $display("FAIL %s busy2 got %b exp %b", x.name, busy2, x.b2);
                end
            end
            if (x.m[1]) begin
                checks++;
                if (rsvFull !== x.f) begin
                    errors++;
                    $display("FAIL %s rsvFull got %b exp %b", x.name, rsvFull, x.f);
                end
            end
            if (x.m[0]) begin
                checks++;
                if (err !== x.e) begin
                    errors++;
                    $display("FAIL %s err got %b exp %b", x.name, err, x.e);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    initial begin
        rst = 1'b0; writeEn = 1'b0; tgt = '0; in = '0;
        rsvEn = 1'b0; rsvTgt = 3'd4; src1 = 3'd3; src2 = 3'd5;
        #2;
        expect_out("reset", 6'h3F, 16'd0, 16'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        @(posedge clk);
        #1 rst = 1'b1;

        // 1: reserve r1..r7, write i*i+10 everywhere, read back from both ports
        for (int i = 1; i < 8; i++) step(1'b0, 3'd0, 16'd0, 1'b1, 3'(i), 3'd0, 3'd0);
        for (int i = 0; i < 8; i++) step(1'b1, 3'(i), 16'(i * i + 10), 1'b0, 3'd0, 3'd0, 3'd0);
        for (int i = 0; i < 8; i++) begin
            step(1'b0, 3'd0, 16'd0, 1'b0, 3'd0, 3'(i), 3'(7 - i));
            expect_out("t1_read", 6'h3D, t1_val(i), t1_val(7 - i), 1'b0, 1'b0, 1'b0, 1'b0);
        end

        // 2: same-cycle bypass
        step(1'b0, 3'd0, 16'd0, 1'b1, 3'd3, 3'd0, 3'd0);
        step(1'b1, 3'd3, 16'hBEEF, 1'b0, 3'd0, 3'd3, 3'd4);
        expect_out("t2_bypass", 6'h3D, 16'hBEEF, 16'd26, 1'b0, 1'b0, 1'b0, 1'b0);
        step(1'b0, 3'd0, 16'd0, 1'b0, 3'd0, 3'd3, 3'd4);
        expect_out("t2_after", 6'h3D, 16'hBEEF, 16'd26, 1'b0, 1'b0, 1'b0, 1'b0);

        // 3: two reservations on r5, retired one at a time
        step(1'b0, 3'd0, 16'd0, 1'b1, 3'd5, 3'd5, 3'd0);
        expect_out("t3_rsv1", 6'h29, 16'd35, 16'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        step(1'b0, 3'd0, 16'd0, 1'b1, 3'd5, 3'd5, 3'd0);
        expect_out("t3_rsv2", 6'h09, 16'd0, 16'd0, 1'b1, 1'b0, 1'b0, 1'b0);
        step(1'b0, 3'd0, 16'd0, 1'b0, 3'd0, 3'd5, 3'd0);
        expect_out("t3_cnt2", 6'h09, 16'd0, 16'd0, 1'b1, 1'b0, 1'b0, 1'b0);
        step(1'b1, 3'd5, 16'd100, 1'b0, 3'd0, 3'd5, 3'd0);
        expect_out("t3_wb1", 6'h29, 16'd100, 16'd0, 1'b1, 1'b0, 1'b0, 1'b0);
        step(1'b1, 3'd5, 16'd200, 1'b0, 3'd0, 3'd5, 3'd0);
        expect_out("t3_wb2", 6'h29, 16'd200, 16'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        step(1'b0, 3'd0, 16'd0, 1'b0, 3'd0, 3'd5, 3'd0);
        expect_out("t3_idle", 6'h29, 16'd200, 16'd0, 1'b0, 1'b0, 1'b0, 1'b0);

        // 4: saturate r4, drop a fourth reservation, then reserve+retire together
        step(1'b0, 3'd0, 16'd0, 1'b1, 3'd4, 3'd0, 3'd4);
        expect_out("t4_r1", 6'h07, 16'd0, 16'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        step(1'b0, 3'd0, 16'd0, 1'b1, 3'd4, 3'd0, 3'd4);
        expect_out("t4_r2", 6'h07, 16'd0, 16'd0, 1'b0, 1'b1, 1'b0, 1'b0);
        step(1'b0, 3'd0, 16'd0, 1'b1, 3'd4, 3'd0, 3'd4);
        expect_out("t4_r3", 6'h07, 16'd0, 16'd0, 1'b0, 1'b1, 1'b0, 1'b0);
        step(1'b0, 3'd0, 16'd0, 1'b1, 3'd4, 3'd0, 3'd4);
        expect_out("t4_r4", 6'h07, 16'd0, 16'd0, 1'b0, 1'b1, 1'b1, 1'b0);
        step(1'b0, 3'd0, 16'd0, 1'b0, 3'd4, 3'd0, 3'd4);
        expect_out("t4_drop", 6'h07, 16'd0, 16'd0, 1'b0, 1'b1, 1'b1, 1'b1);
        step(1'b1, 3'd4, 16'h0044, 1'b1, 3'd4, 3'd0, 3'd4);
        expect_out("t4_both", 6'h17, 16'd0, 16'h0044, 1'b0, 1'b1, 1'b1, 1'b1);
        step(1'b0, 3'd0, 16'd0, 1'b0, 3'd4, 3'd0, 3'd4);
        expect_out("t4_hold", 6'h17, 16'd0, 16'h0044, 1'b0, 1'b1, 1'b1, 1'b1);

        // 6: asynchronous reset between edges with live state
        @(posedge clk);
        #1;
        writeEn = 1'b0; rsvEn = 1'b0; rsvTgt = 3'd4; src1 = 3'd4; src2 = 3'd3;
        rst = 1'b0;
        expect_out("t6_async_rst", 6'h3F, 16'd0, 16'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        @(posedge clk);
        #1 rst = 1'b1;

        // 5: r0 is inert, then a write to r6 with nothing pending
        step(1'b1, 3'd0, 16'h1234, 1'b1, 3'd0, 3'd0, 3'd0);
        expect_out("t5_r0_both", 6'h3F, 16'd0, 16'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        step(1'b0, 3'd0, 16'd0, 1'b1, 3'd0, 3'd0, 3'd0);
        expect_out("t5_r0_rsv", 6'h3F, 16'd0, 16'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        step(1'b1, 3'd6, 16'h0066, 1'b0, 3'd0, 3'd6, 3'd0);
        expect_out("t5_uf_pre", 6'h21, 16'h0066, 16'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        step(1'b0, 3'd0, 16'd0, 1'b0, 3'd0, 3'd6, 3'd0);
        expect_out("t5_uf_post", 6'h29, 16'h0066, 16'd0, 1'b0, 1'b0, 1'b0, 1'b1);

        @(posedge clk);
        @(posedge clk);
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain pending %0d exp 0", exp_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
